// File: rtl/wave_pkg.sv
// Shared definitions for the wavetable channel: output-level codes, sample scaling
// and the length-counter width rule.
package wave_pkg;

  typedef enum logic [1:0] {
    LVL_MUTE    = 2'b00,
    LVL_FULL    = 2'b01,
    LVL_HALF    = 2'b10,
    LVL_QUARTER = 2'b11
  } level_code_e;

  // Widest sample the scaler handles; callers zero-extend and truncate.
  localparam int SCALE_W = 16;

  function automatic int len_cnt_w(input int len_w);
    return len_w + 1;
  endfunction

  function automatic logic [SCALE_W-1:0] scale_sample(input logic [SCALE_W-1:0] s,
                                                      input logic [1:0] code);
    logic [SCALE_W-1:0] r;
    r = '0;
    case (code)
      LVL_FULL:    r = s;
      LVL_HALF:    r = s >> 1;
      LVL_QUARTER: r = s >> 2;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wave_ram.sv
// Sample RAM: one synchronous write port, combinational read (a same-cycle write
// is not seen by the read until after the edge).
module wave_ram #(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wave_channel.sv
// Wavetable sound channel: steps through sample RAM at a programmable period, scales
// the output and stops on length expiry. Optional banked RAM under WAVE_CHANNEL_BANK_EN.
module wave_channel
  import wave_pkg::*;
#(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  parameter int FREQ_W   = 11,
  parameter int LEN_W    = 8,
  localparam int ADDR_W  = $clog2(DEPTH),
`ifdef WAVE_CHANNEL_BANK_EN
  localparam int IDX_W   = ADDR_W + 1
`else
  localparam int IDX_W   = ADDR_W
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                trigger,
  input  logic                dac_en,
  input  logic                length_load,
  input  logic [LEN_W-1:0]    length_data,
  input  logic                length_en,
  input  logic                length_tick,
  input  logic [1:0]          output_level,
  input  logic [FREQ_W-1:0]   freq_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
`ifdef WAVE_CHANNEL_BANK_EN
  input  logic                bank_sel,
  input  logic                dim_mode,
`endif
  output logic [SAMPLE_W-1:0] level,
  output logic                active,
  output logic [IDX_W-1:0]    sample_idx
);

  localparam int TW  = FREQ_W + 1;
  localparam int LCW = len_cnt_w(LEN_W);
`ifdef WAVE_CHANNEL_BANK_EN
  localparam int RAM_DEPTH = 2 * DEPTH;
`else
  localparam int RAM_DEPTH = DEPTH;
`endif
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [TW-1:0]       timer, timer_nxt, period;
  logic [LCW-1:0]      len_cnt, len_nxt, len_full, len_load_val, len_base;
  logic [IDX_W-1:0]    idx_nxt, idx_inc;
  logic [SAMPLE_W-1:0] level_nxt, rd_data;
  logic                active_nxt, step, len_dec;
  logic                ram_wr_en;
  logic [RAM_AW-1:0]   ram_wr_addr, ram_rd_addr;

  assign period       = (TW'(1) << FREQ_W) - TW'(freq_data);
  assign len_full     = LCW'(1) << LEN_W;
  assign len_load_val = len_full - LCW'(length_data);

  // Position of the sample that the next step will play.
  always_comb begin
    idx_inc = sample_idx + IDX_W'(1);
`ifdef WAVE_CHANNEL_BANK_EN
    if (!dim_mode) idx_inc[IDX_W-1] = 1'b0;
`endif
  end

`ifdef WAVE_CHANNEL_BANK_EN
  // Playback bank is bank_sel, offset by the wide index in dim mode; CPU writes
  // land in the other bank and are dropped while both banks are playing.
  assign ram_rd_addr = {idx_inc[ADDR_W] ^ bank_sel, idx_inc[ADDR_W-1:0]};
  assign ram_wr_addr = {~bank_sel, wr_addr};
  assign ram_wr_en   = wr_en & ~dim_mode;
`else
  assign ram_rd_addr = idx_inc;
  assign ram_wr_addr = wr_addr;
  assign ram_wr_en   = wr_en;
`endif

  wave_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (RAM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    step       = active && (timer == TW'(1));
    len_base   = length_load ? len_load_val : len_cnt;
    len_dec    = !trigger && !length_load && length_tick && length_en && (len_cnt != '0);
    active_nxt = active;
    timer_nxt  = timer;
    idx_nxt    = sample_idx;
    len_nxt    = len_cnt;
    level_nxt  = level;

    if (trigger) begin
      // Load is applied before the zero-reload check; a coincident tick is ignored.
      active_nxt = dac_en;
      timer_nxt  = period;
      idx_nxt    = '0;
      len_nxt    = (len_base == '0) ? len_full : len_base;
    end else begin
      len_nxt = len_dec ? (len_cnt - LCW'(1)) : len_base;
      if (!dac_en || (len_dec && len_cnt == LCW'(1))) active_nxt = 1'b0;
      if (active) begin
        timer_nxt = step ? period : (timer - TW'(1));
        if (step) idx_nxt = idx_inc;
      end
    end

    if (!active)
      level_nxt = '0;
    else if (step && !trigger)
      level_nxt = SAMPLE_W'(scale_sample(SCALE_W'(rd_data), output_level));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= 1'b0;
      timer      <= '0;
      sample_idx <= '0;
      len_cnt    <= '0;
      level      <= '0;
    end else begin
      active     <= active_nxt;
      timer      <= timer_nxt;
      sample_idx <= idx_nxt;
      len_cnt    <= len_nxt;
      level      <= level_nxt;
    end
  end

endmodule

// File: tb/tb_wave_channel.sv
// Directed-plus-random bench for wave_channel; expected levels come from position
// arithmetic (cycles since trigger / period) over a model copy of the sample RAM.
module tb_wave_channel;

`ifdef WAVE_CHANNEL_BANK_EN
  localparam int IDX_W = 6;
`else
  localparam int IDX_W = 5;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trigger, dac_en, length_load, length_en, length_tick, wr_en;
  logic [7:0]  length_data;
  logic [1:0]  output_level;
  logic [10:0] freq_data;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [3:0]  level;
  logic        active;
  logic [IDX_W-1:0] sample_idx;
`ifdef WAVE_CHANNEL_BANK_EN
  logic        bank_sel, dim_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ram_m [64];
  int last_level = 0;
  int bank_m = 0;
  int span_m = 32;
  logic [3:0] exp_q [$];

  wave_channel dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .dac_en       (dac_en),
    .length_load  (length_load),
    .length_data  (length_data),
    .length_en    (length_en),
    .length_tick  (length_tick),
    .output_level (output_level),
    .freq_data    (freq_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
`ifdef WAVE_CHANNEL_BANK_EN
    .bank_sel     (bank_sel),
    .dim_mode     (dim_mode),
`endif
    .level        (level),
    .active       (active),
    .sample_idx   (sample_idx)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_scale(input int s, input int code);
    case (code)
      1:       return s;
      2:       return s / 2;
      3:       return s / 4;
      default: return 0;
    endcase
  endfunction

  // Address a: 0..31 bank 0, 32..63 bank 1 (only bank 0 exists without the macro).
  task automatic write_ram(input int a, input int d);
    bit dropped;
    dropped = 1'b0;
`ifdef WAVE_CHANNEL_BANK_EN
    bank_sel = (a < 32);
    dropped  = dim_mode;
`endif
    wr_en   = 1'b1;
    wr_addr = 5'(a % 32);
    wr_data = 4'(d);
    if (!dropped) ram_m[a % 64] = d;
    step_clk();
    wr_en = 1'b0;
`ifdef WAVE_CHANNEL_BANK_EN
    bank_sel = 1'(bank_m);
`endif
  endtask

  task automatic stop_channel();
    dac_en = 1'b0;
    step_clk();
    step_clk();
    check("stop_level", 32'(level), 32'd0);
    dac_en = 1'b1;
    last_level = 0;
  endtask

  // Trigger with period p, then compare level and position for ncyc cycles.
  task automatic play_check(input int p, input int ncyc, input string tag);
    int hold, k, a;
    hold      = last_level;
    freq_data = 11'(2048 - p);
    trigger   = 1'b1;
    step_clk();
    trigger     = 1'b0;
    length_load = 1'b0;
    length_tick = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      k = (n / p) % span_m;
      a = (k + bank_m * 32) % 64;
      exp_q.push_back(4'((n < p) ? hold : ref_scale(ram_m[a], int'(output_level))));
    end
    for (int n = 0; n < ncyc; n++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check({tag, "_level"}, 32'(level), 32'(e));
      check({tag, "_idx"}, 32'(sample_idx), 32'((n / p) % span_m));
      last_level = int'(e);
      if (n < ncyc - 1) step_clk();
    end
  endtask

  // Hold length_tick for `ticks` edges; the channel must drop on the last one.
  task automatic expire_check(input int ticks);
    for (int k = 1; k <= ticks; k++) begin
      length_tick = 1'b1;
      step_clk();
      length_tick = 1'b0;
      check("len_active", 32'(active), 32'(k < ticks));
    end
    check("len_level_hold", 32'(level), 32'(last_level));
    step_clk();
    check("len_level_zero", 32'(level), 32'd0);
    last_level = 0;
  endtask

  initial begin
    int ld, p;
    reset_n = 1'b0;
    trigger = 1'b0; dac_en = 1'b1; length_load = 1'b0; length_en = 1'b0;
    length_tick = 1'b0; wr_en = 1'b0; length_data = '0; output_level = 2'd1;
    freq_data = '0; wr_addr = '0; wr_data = '0;
`ifdef WAVE_CHANNEL_BANK_EN
    bank_sel = 1'b0; dim_mode = 1'b0;
`endif
    step_clk();
    step_clk();
    check("rst_level", 32'(level), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_idx", 32'(sample_idx), 32'd0);
    reset_n = 1'b1;
    step_clk();

    // Ramp 0..15,0..15 at P=4 including the 31->0 wrap
    for (int i = 0; i < 32; i++) write_ram(i, i % 16);
    play_check(4, 132, "ramp");

    // Output-level scaling on full-scale samples
    stop_channel();
    for (int i = 0; i < 32; i++) write_ram(i, 15);
    for (int c = 0; c < 4; c++) begin
      output_level = 2'((c + 1) % 4);
      play_check(4, 6, "scale");
    end
    output_level = 2'd1;

    // Asynchronous reset mid-play
    play_check(4, 6, "pre_rst");
    #2 reset_n = 1'b0;
    #1;
    check("async_level", 32'(level), 32'd0);
    check("async_active", 32'(active), 32'd0);
    check("async_idx", 32'(sample_idx), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    last_level = 0;

    // Length expiry with a random short length
    length_en   = 1'b1;
    ld          = $urandom_range(252, 255);
    length_data = 8'(ld);
    length_load = 1'b1;
    step_clk();
    length_load = 1'b0;
    play_check(4, 6, "len_a");
    expire_check(256 - ld);

    // Expired counter reloads to full length on trigger
    play_check(4, 6, "len_reload");
    expire_check(256);

    // length_en low: ticks do not stop playback
    length_en   = 1'b0;
    length_data = 8'hFE;
    length_load = 1'b1;
    step_clk();
    length_load = 1'b0;
    play_check(4, 6, "len_off");
    length_tick = 1'b1;
    for (int i = 0; i < 5; i++) step_clk();
    length_tick = 1'b0;
    check("len_off_active", 32'(active), 32'd1);

    // Trigger coinciding with length_load: new length in force
    length_en   = 1'b1;
    length_data = 8'hFD;
    length_load = 1'b1;
    play_check(4, 6, "trig_load");
    expire_check(3);

    // Trigger coinciding with length_tick: tick ignored
    length_data = 8'hFE;
    length_load = 1'b1;
    step_clk();
    length_load = 1'b0;
    length_tick = 1'b1;
    play_check(4, 6, "trig_tick");
    expire_check(2);
    length_en = 1'b0;

    // DAC disabled at trigger, then dropped mid-play
    dac_en  = 1'b0;
    trigger = 1'b1;
    step_clk();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("dac_off_active", 32'(active), 32'd0);
      check("dac_off_level", 32'(level), 32'd0);
      step_clk();
    end
    dac_en = 1'b1;
    play_check(3, 8, "dac_play");
    dac_en = 1'b0;
    step_clk();
    check("dac_drop_active", 32'(active), 32'd0);
    step_clk();
    check("dac_drop_level", 32'(level), 32'd0);
    dac_en = 1'b1;
    last_level = 0;

    // Random sample tables, periods and volume codes
    for (int r = 0; r < 5; r++) begin
      stop_channel();
      for (int i = 0; i < 32; i++) write_ram(i, int'($urandom_range(0, 15)));
      p = $urandom_range(1, 7);
      output_level = 2'($urandom_range(0, 3));
      play_check(p, p * 33 + 2, "rand");
    end

`ifdef WAVE_CHANNEL_BANK_EN
    // Dual-bank playback across 64 samples; dim-mode writes are dropped
    stop_channel();
    output_level = 2'd1;
    for (int i = 0; i < 32; i++) write_ram(i, 1);
    for (int i = 0; i < 32; i++) write_ram(32 + i, 2);
    bank_m = 0; bank_sel = 1'b0;
    dim_mode = 1'b1; span_m = 64;
    play_check(2, 132, "dim");
    write_ram(5, 15);
    stop_channel();
    play_check(2, 14, "dim_wr");
    dim_mode = 1'b0; span_m = 32;
    stop_channel();
    bank_m = 1; bank_sel = 1'b1;
    play_check(2, 10, "bank1");
    bank_m = 0; bank_sel = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_channel.md
# wave_channel

Parametrised wavetable sound channel, successor to the fixed 32×4-bit wave player. Holds a writable sample RAM, steps through it at a programmable frequency, applies output-level scaling and an optional length cut-off, and reports channel activity. Sits between the sound register file (CPU writes, trigger strobes) and the channel mixer (`level`).

## Interface

Parameters:
- `SAMPLE_W`, 4, bits per sample.
- `DEPTH`, 32, samples per bank; power of two, ≥ 4.
- `FREQ_W`, 11, frequency register width.
- `LEN_W`, 8, length register width.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `trigger`  in  1  one-cycle pulse; (re)start playback.
- `dac_en`  in  1  channel DAC enable; low forces the channel inactive.
- `length_load`  in  1  one-cycle pulse; load the length counter.
- `length_data`  in  LEN_W  length value.
- `length_en`  in  1  stop on length expiry (non-looping mode).
- `length_tick`  in  1  one-cycle 256 Hz strobe; synchronous enable, not a clock.
- `output_level`  in  2  volume code.
- `freq_data`  in  FREQ_W  frequency value.
- `wr_en`  in  1  sample RAM write strobe.
- `wr_addr`  in  $clog2(DEPTH)  sample write address.
- `wr_data`  in  SAMPLE_W  sample write data.
- `level`  out  SAMPLE_W  registered sample output.
- `active`  out  1  channel playing.
- `sample_idx`  out  $clog2(DEPTH)  current play position.

## Operation

- Period is P = 2^FREQ_W − freq_data, in clk cycles, with range 1..2^FREQ_W. A down-counter `timer` runs only while `active`.
- Trigger: `active` ← dac_en; `timer` ← P; `sample_idx` ← 0. If the length counter is 0, it reloads to 2^LEN_W. `level` holds its value.
- Step: when `active` and `timer`==1, on the next edge: `timer` ← P; `sample_idx` ← sample_idx+1 (wraps DEPTH−1→0); `level` ← scale(ram[sample_idx+1]). The first sample played after a trigger is index 1.
- Scaling: 00 gives 0; 01 gives s; 10 gives s>>1; 11 gives s>>2.
- Length: `length_load` sets the counter to 2^LEN_W − length_data (width LEN_W+1). On `length_tick` with `length_en` set and the counter ≠ 0, the counter decrements. When it reaches 0, `active` ← 0.
- `dac_en` low: `active` ← 0 on the next edge.
- Whenever `active` is 0, `level` ← 0 on the next edge.
- RAM has one write port and a combinational read. If a write hits the address being stepped to in the same cycle, the step uses the old data.
- Simultaneous events:
  - trigger with length_tick: trigger wins and the tick is ignored.
  - trigger with length_load: the load applies first, then the zero-reload check.
  - trigger while active: full restart.

## Timing

- Reset values: `level`=0, `active`=0, `sample_idx`=0, `timer`=0, length counter=0. The RAM is not reset; the bench writes it before use.
- Reset assertion takes effect immediately (asynchronous), including mid-playback.
- After a trigger at edge E, `level` first changes at edge E+P, then every P cycles.
- `active` falls one edge after the terminating tick or `dac_en` drop. `level` reaches 0 one edge after that.
- A RAM write is visible to steps starting the cycle after the write.

## Configuration

- `WAVE_CHANNEL_BANK_EN` defined:
  - RAM becomes 2 banks × DEPTH.
  - Adds inputs `bank_sel` (1) and `dim_mode` (1).
  - Playback uses bank `bank_sel`. With `dim_mode`=1, playback runs over 2·DEPTH samples starting in `bank_sel`, and `sample_idx` widens by 1.
  - CPU writes always target the non-playing bank. In dim_mode, writes are dropped.
- Undefined: single bank; the ports above are absent.

## Structure

- Package `wave_pkg`: output-level code constants, a `scale_sample` function, and the length-counter width expression.
- Sub-module `wave_ram`: one write port, combinational read, parametrised by SAMPLE_W and depth.

## Test plan

1. Write samples 0..15,0..15; freq_data=2^11−4 (P=4); output_level=01; trigger → `level` shows 1,2,…,15,0,1… changing every 4 cycles, and `sample_idx` wraps 31→0.
2. All samples 0xF; output_level 01/10/11/00 → `level` 15/7/3/0.
3. length_data=0xFE, length_en=1, trigger, then two length_tick pulses → `active` falls one edge after the 2nd tick and `level`=0 the edge after. With length_en=0, it keeps playing.
4. Trigger with dac_en=0 → `active` stays 0 and `level` stays 0. Drop dac_en mid-play → same response.
5. Assert reset_n low mid-play → `level`, `active`, `sample_idx` go to 0 without a clock edge. Trigger plus length_tick in the same cycle → counter not decremented.
6. With the macro: bank 0 = 0x1, bank 1 = 0x2, dim_mode=1, P=2 → 32 steps of 1 then 32 steps of 2. A write in dim_mode leaves the RAM unchanged.
